// File: rtl/frame_bank_pkg.sv
// Shared definitions for the frame bank scheduler.
//   - wr_state_e      : write-side FSM state encoding
//   - DefaultNumBanks : default number of frame buffer banks
//   - BankW           : width of a bank index
//   - bank_inc()      : modulo-N bank increment
package frame_bank_pkg;

  localparam int unsigned DefaultNumBanks = 4;
  localparam int unsigned BankW           = 2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWrite
  } wr_state_e;

  // (bank + 1) mod num_banks
  function automatic logic [BankW-1:0] bank_inc(input logic [BankW-1:0] bank,
                                                input int unsigned      num_banks);
    if (32'(bank) + 32'd1 >= num_banks) begin
      return '0;
    end
    return BankW'(32'(bank) + 32'd1);
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Synchronizes an asynchronous vsync into the pclk domain and flags its rising edge.
// Ports:
//   pclk     - clock
//   rst_n    - asynchronous active-low reset
//   async_in - raw vsync from the camera
//   rise     - one-cycle flag: last sync stage is 1 and the edge flop is still 0
module vsync_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Frame buffer bank scheduler: hands the camera write engine a free bank on every vsync,
// publishes completed frames, and lets the display latch the latest completed bank.
// Ports:
//   pclk, rst_n    - clock, asynchronous active-low reset
//   wr_vsync       - raw camera vsync (asynchronous)
//   write_req      - start request to the write engine, held until write_req_ack
//   write_req_ack  - acknowledge pulse from the write engine
//   write_bank     - bank the write engine fills
//   wr_frame_done  - write engine finished the current frame (pulse)
//   rd_frame_start - display frame start (pulse)
//   read_bank      - bank the display reads
//   read_valid     - read_bank holds a completed frame
//   frame_drop     - one-cycle pulse when an in-progress frame is abandoned
module frame_bank_scheduler
  import frame_bank_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = DefaultNumBanks,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             wr_vsync,
  output logic             write_req,
  input  logic             write_req_ack,
  output logic [BankW-1:0] write_bank,
  input  logic             wr_frame_done,
  input  logic             rd_frame_start,
  output logic [BankW-1:0] read_bank,
  output logic             read_valid,
  output logic             frame_drop
);

  wr_state_e        state_q, state_d;
  logic             write_req_q, write_req_d;
  logic [BankW-1:0] write_bank_q, write_bank_d;
  logic [BankW-1:0] read_bank_q, read_bank_d;
  logic             read_valid_q, read_valid_d;
  logic [BankW-1:0] latest_bank_q, latest_bank_d;
  logic             latest_valid_q, latest_valid_d;
  logic             frame_drop_q, frame_drop_d;
  logic             vsync_rise;
  logic             done_in_write;
  logic             enter_req;

  vsync_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_vsync_edge_sync (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .async_in(wr_vsync),
    .rise    (vsync_rise)
  );

  // Next candidate after cur, skipping at most twice over banks the display holds or
  // that hold the latest completed frame.
  function automatic logic [BankW-1:0] select_bank(input logic [BankW-1:0] cur,
                                                   input logic [BankW-1:0] rb,
                                                   input logic             rv,
                                                   input logic [BankW-1:0] lb,
                                                   input logic             lv);
    logic [BankW-1:0] cand;
    cand = bank_inc(cur, NUM_BANKS);
    for (int i = 0; i < 2; i++) begin
      if ((rv && cand == rb) || (lv && cand == lb)) begin
        cand = bank_inc(cand, NUM_BANKS);
      end
    end
    return cand;
  endfunction

  assign done_in_write = wr_frame_done && (state_q == StWrite);

  always_comb begin
    state_d        = state_q;
    write_req_d    = write_req_q;
    write_bank_d   = write_bank_q;
    read_bank_d    = read_bank_q;
    read_valid_d   = read_valid_q;
    latest_bank_d  = latest_bank_q;
    latest_valid_d = latest_valid_q;
    frame_drop_d   = 1'b0;
    enter_req      = 1'b0;

    if (done_in_write) begin
      latest_bank_d  = write_bank_q;
      latest_valid_d = 1'b1;
    end

    // Using latest_*_d gives the same-cycle bypass of a just-completed frame.
    if (rd_frame_start && latest_valid_d) begin
      read_bank_d  = latest_bank_d;
      read_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (vsync_rise) enter_req = 1'b1;
      end
      StReq: begin
        // A new vsync while still waiting: the frame is lost, request stays as is.
        if (vsync_rise) begin
          frame_drop_d = 1'b1;
        end else if (write_req_ack) begin
          state_d     = StWrite;
          write_req_d = 1'b0;
        end
      end
      StWrite: begin
        if (done_in_write) begin
          if (vsync_rise) enter_req = 1'b1;
          else            state_d   = StIdle;
        end else if (vsync_rise) begin
          frame_drop_d = 1'b1;
          enter_req    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Selection sees this cycle's publish/read updates so the new write bank never
    // collides with what the display may latch next.
    if (enter_req) begin
      state_d      = StReq;
      write_req_d  = 1'b1;
      write_bank_d = select_bank(write_bank_q, read_bank_d, read_valid_d,
                                 latest_bank_d, latest_valid_d);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      write_req_q    <= 1'b0;
      write_bank_q   <= '0;
      read_bank_q    <= '0;
      read_valid_q   <= 1'b0;
      latest_bank_q  <= '0;
      latest_valid_q <= 1'b0;
      frame_drop_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      write_req_q    <= write_req_d;
      write_bank_q   <= write_bank_d;
      read_bank_q    <= read_bank_d;
      read_valid_q   <= read_valid_d;
      latest_bank_q  <= latest_bank_d;
      latest_valid_q <= latest_valid_d;
      frame_drop_q   <= frame_drop_d;
    end
  end

  assign write_req  = write_req_q;
  assign write_bank = write_bank_q;
  assign read_bank  = read_bank_q;
  assign read_valid = read_valid_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Bench for frame_bank_scheduler: a 4-bank and a 3-bank instance share stimulus and are
// each checked every cycle against an event-level model of the scheduling rules.
module tb_frame_bank_scheduler;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_vsync = 1'b0;
  logic       write_req_ack = 1'b0;
  logic       wr_frame_done = 1'b0;
  logic       rd_frame_start = 1'b0;

  logic       wreq4, rv4, fd4, wreq3, rv3, fd3;
  logic [1:0] wb4, rb4, wb3, rb3;

  always #5 pclk = ~pclk;

  frame_bank_scheduler #(
    .NUM_BANKS  (4),
    .SYNC_STAGES(2)
  ) dut4 (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .wr_vsync      (wr_vsync),
    .write_req     (wreq4),
    .write_req_ack (write_req_ack),
    .write_bank    (wb4),
    .wr_frame_done (wr_frame_done),
    .rd_frame_start(rd_frame_start),
    .read_bank     (rb4),
    .read_valid    (rv4),
    .frame_drop    (fd4)
  );

  frame_bank_scheduler #(
    .NUM_BANKS  (3),
    .SYNC_STAGES(2)
  ) dut3 (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .wr_vsync      (wr_vsync),
    .write_req     (wreq3),
    .write_req_ack (write_req_ack),
    .write_bank    (wb3),
    .wr_frame_done (wr_frame_done),
    .rd_frame_start(rd_frame_start),
    .read_bank     (rb3),
    .read_valid    (rv3),
    .frame_drop    (fd3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MIdle  = 0;
  localparam int MReq   = 1;
  localparam int MWrite = 2;

  int nb[2]   = '{4, 3};
  int m_st[2] = '{0, 0};
  int m_wb[2] = '{0, 0};
  int m_rb[2] = '{0, 0};
  int m_lb[2] = '{0, 0};
  bit m_rv[2] = '{0, 0};
  bit m_lv[2] = '{0, 0};
  bit m_fd[2] = '{0, 0};
  // vs_hist[k]: wr_vsync as sampled k+1 clock edges ago
  bit vs_hist[3] = '{0, 0, 0};

  function automatic int pick(input int i, input int cur);
    int c;
    c = (cur + 1) % nb[i];
    repeat (2) begin
      if ((m_rv[i] && c == m_rb[i]) || (m_lv[i] && c == m_lb[i])) c = (c + 1) % nb[i];
    end
    return c;
  endfunction

  always @(posedge pclk or negedge rst_n) begin
    bit vs_rise, done_w, enter;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = MIdle; m_wb[i] = 0; m_rb[i] = 0; m_lb[i] = 0;
        m_rv[i] = 0; m_lv[i] = 0; m_fd[i] = 0;
      end
      vs_hist = '{0, 0, 0};
    end else begin
      // With two sync stages, a rise is a high sampled two edges ago after a low three ago.
      vs_rise = vs_hist[1] && !vs_hist[2];
      for (int i = 0; i < 2; i++) begin
        done_w  = wr_frame_done && m_st[i] == MWrite;
        enter   = 0;
        m_fd[i] = 0;
        if (done_w) begin
          m_lb[i] = m_wb[i];
          m_lv[i] = 1;
        end
        if (rd_frame_start && m_lv[i]) begin
          m_rb[i] = m_lb[i];
          m_rv[i] = 1;
        end
        case (m_st[i])
          MIdle:  if (vs_rise) enter = 1;
          MReq: begin
            if (vs_rise) m_fd[i] = 1;
            else if (write_req_ack) m_st[i] = MWrite;
          end
          default: begin
            if (done_w) begin
              if (vs_rise) enter = 1;
              else m_st[i] = MIdle;
            end else if (vs_rise) begin
              m_fd[i] = 1;
              enter   = 1;
            end
          end
        endcase
        if (enter) begin
          m_st[i] = MReq;
          m_wb[i] = pick(i, m_wb[i]);
        end
      end
      vs_hist[2] = vs_hist[1];
      vs_hist[1] = vs_hist[0];
      vs_hist[0] = wr_vsync;
    end
  end

  task automatic cmp_inst(input int i, input string tag, input logic wr, input logic [1:0] wb,
                          input logic [1:0] rb, input logic rv, input logic fd);
    check({tag, " write_req"}, 32'(wr), 32'(m_st[i] == MReq));
    check({tag, " write_bank"}, 32'(wb), 32'(m_wb[i]));
    check({tag, " read_bank"}, 32'(rb), 32'(m_rb[i]));
    check({tag, " read_valid"}, 32'(rv), 32'(m_rv[i]));
    check({tag, " frame_drop"}, 32'(fd), 32'(m_fd[i]));
  endtask

  // Single compare process, away from the active edge.
  always @(negedge pclk) begin
    cmp_inst(0, "nb4", wreq4, wb4, rb4, rv4, fd4);
    cmp_inst(1, "nb3", wreq3, wb3, rb3, rv3, fd3);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic vs_edge();
    wr_vsync = 1'b0;
    repeat (4) tick();
    wr_vsync = 1'b1;
    repeat (3) tick();
  endtask

  task automatic pulse_ack();
    write_req_ack = 1'b1;
    tick();
    write_req_ack = 1'b0;
  endtask

  task automatic pulse_done(input bit with_rd);
    wr_frame_done  = 1'b1;
    rd_frame_start = with_rd;
    tick();
    wr_frame_done  = 1'b0;
    rd_frame_start = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_frame_start = 1'b1;
    tick();
    rd_frame_start = 1'b0;
  endtask

  initial begin
    bit prev_ack, prev_done, prev_rd;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset write_req", 32'(wreq4), 0);
    check("reset read_valid", 32'(rv4), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // First vsync after reset: request on the 3rd edge, bank 1.
    wr_vsync = 1'b1;
    tick();
    tick();
    check("req not before 3rd edge", 32'(wreq4), 0);
    tick();
    check("req on 3rd edge", 32'(wreq4), 1);
    check("first bank", 32'(wb4), 1);
    pulse_ack();
    check("req drops after ack", 32'(wreq4), 0);

    // Complete bank 1, display latches it, next frame goes to bank 2.
    pulse_done(0);
    pulse_rd();
    check("read bank 1", 32'(rb4), 1);
    check("read valid", 32'(rv4), 1);
    vs_edge();
    check("next bank 2", 32'(wb4), 2);
    check("nb3 next bank 2", 32'(wb3), 2);
    pulse_ack();
    pulse_done(0);

    // read=1, latest=2: nb4 takes 3, nb3 wraps to 0.
    vs_edge();
    check("nb4 bank 3", 32'(wb4), 3);
    check("nb3 bank 0", 32'(wb3), 0);
    pulse_ack();

    // Drop in WRITE: nb3 skips 1 and 2 and lands back on 0.
    vs_edge();
    check("drop pulse", 32'(fd4), 1);
    check("req again", 32'(wreq4), 1);
    check("nb3 two skips", 32'(wb3), 0);
    check("nb4 after drop", 32'(wb4), 0);
    tick();
    check("drop one cycle", 32'(fd4), 0);
    pulse_rd();
    check("abandoned bank not published", 32'(rb4), 2);

    // Walk nb4 to bank 3, then finish it in the same cycle as a display start.
    pulse_ack();
    pulse_done(0);
    vs_edge();
    pulse_ack();
    pulse_done(0);
    vs_edge();
    check("nb4 bank 3 again", 32'(wb4), 3);
    pulse_ack();
    pulse_done(1);
    check("bypass read bank", 32'(rb4), 3);
    check("bypass read valid", 32'(rv4), 1);

    // Reset in WRITE clears outputs without waiting for a clock.
    vs_edge();
    pulse_ack();
    wr_vsync = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("async rst write_req", 32'(wreq4), 0);
    check("async rst write_bank", 32'(wb4), 0);
    check("async rst read_bank", 32'(rb4), 0);
    check("async rst read_valid", 32'(rv4), 0);
    check("async rst frame_drop", 32'(fd4), 0);
    tick();
    rst_n = 1'b1;
    vs_edge();
    check("post reset bank 1", 32'(wb4), 1);

    // Randomized traffic, including occasional mid-run resets.
    prev_ack = 0; prev_done = 0; prev_rd = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 9) == 0) wr_vsync = ~wr_vsync;
      write_req_ack  = !prev_ack && ($urandom_range(0, 2) == 0);
      wr_frame_done  = !prev_done && ($urandom_range(0, 7) == 0);
      rd_frame_start = !prev_rd && ($urandom_range(0, 5) == 0);
      prev_ack  = write_req_ack;
      prev_done = wr_frame_done;
      prev_rd   = rd_frame_start;
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    write_req_ack  = 1'b0;
    wr_frame_done  = 1'b0;
    rd_frame_start = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
